// File: rtl/mux_scan_ctrl_if.sv
// Signal bundle between the scan sequencer and its environment (mux output in, selects/snapshot out).
// master drives start/mask and returns the mux output f; slave is the sequencer itself.
interface mux_scan_ctrl_if;
  logic       start;
  logic [3:0] mask;
  logic       f;
  logic       s1;
  logic       s0;
  logic       busy;
  logic [3:0] sample;
  logic       done;

  modport master (
    output start,
    output mask,
    output f,
    input  s1,
    input  s0,
    input  busy,
    input  sample,
    input  done
  );

  modport slave (
    input  start,
    input  mask,
    input  f,
    output s1,
    output s0,
    output busy,
    output sample,
    output done
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps mux4by1 selects over the enabled channels, sampling f after DWELL cycles each; done N*DWELL cycles after start.
// No backpressure: start is only honoured in IDLE and is dropped (not queued) while a scan is running.
module mux_scan_ctrl #(
  parameter int DWELL = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_scan_ctrl_if.slave bus
);

  localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] ch_q, ch_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] work_q, work_d;
  logic [3:0] sample_q, sample_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [1:0] first_ch;
  logic [1:0] next_ch;
  logic       has_next;

  // Descending walk so the lowest qualifying index is the one that sticks.
  always_comb begin : pick_channel
    first_ch = 2'd0;
    next_ch  = 2'd0;
    has_next = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (bus.mask[k]) begin
        first_ch = 2'(k);
      end
      if (mask_q[k] && (k > int'(ch_q))) begin
        next_ch  = 2'(k);
        has_next = 1'b1;
      end
    end
  end

  always_comb begin : next_state
    state_d  = state_q;
    ch_d     = ch_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    work_d   = work_q;
    sample_d = sample_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && (bus.mask != 4'b0000)) begin
          mask_d  = bus.mask;
          ch_d    = first_ch;
          sel_d   = first_ch;
          cnt_d   = 8'd0;
          busy_d  = 1'b1;
          work_d  = 4'b0000;
          state_d = SCAN;
        end
      end

      SCAN: begin
        if (cnt_q < CNT_LAST) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          work_d[ch_q] = bus.f;
          if (has_next) begin
            ch_d  = next_ch;
            sel_d = next_ch;
            cnt_d = 8'd0;
          end else begin
            // Last channel's bit comes straight from f so the snapshot lands on this edge.
            sample_d       = work_q;
            sample_d[ch_q] = bus.f;
            done_d         = 1'b1;
            busy_d         = 1'b0;
            sel_d          = 2'd0;
            state_d        = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        sel_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      state_q  <= IDLE;
      ch_q     <= 2'd0;
      sel_q    <= 2'd0;
      cnt_q    <= 8'd0;
      mask_q   <= 4'b0000;
      work_q   <= 4'b0000;
      sample_q <= 4'b0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      work_q   <= work_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.s1     = sel_q[1];
  assign bus.s0     = sel_q[0];
  assign bus.busy   = busy_q;
  assign bus.sample = sample_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (DWELL=4 and DWELL=1) each reading a modelled 4:1 mux.
// Expected selects/snapshots come from a timeline model of the scan schedule.
module tb_mux_scan_ctrl;

  localparam int D4 = 4;

  logic clk;
  logic rst_n;
  logic [3:0] i4;
  logic [3:0] i1;
  logic [3:0] last_sample4;
  int n_cmp;
  int n_fail;

  mux_scan_ctrl_if if4 ();
  mux_scan_ctrl_if if1 ();

  assign if4.f = i4[{if4.s1, if4.s0}];
  assign if1.f = i1[{if1.s1, if1.s0}];

  mux_scan_ctrl #(.DWELL(D4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  mux_scan_ctrl #(.DWELL(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one scan on the DWELL=4 instance. mode: 0 hold inputs, 1 random inputs every cycle,
  // 2 toggle i0 at dwell cycles 1 and 3, 3 re-pulse start and change mask mid-scan.
  task automatic run_scan(input logic [3:0] m, input int mode, input string name);
    int en[$];
    int total;
    int ch;
    logic [3:0] exp;
    logic [1:0] sel;
    en = {};
    for (int k = 0; k < 4; k++) if (m[k]) en.push_back(k);
    total = en.size() * D4;
    exp = 4'b0000;
    if4.mask = m;
    if4.start = 1'b1;
    step();
    if4.start = 1'b0;
    for (int k = 0; k < total; k++) begin
      case (mode)
        1: i4 = 4'($urandom);
        2: if (k == 1 || k == 3) i4[0] = ~i4[0];
        3: begin
          if (k == 2) begin
            if4.start = 1'b1;
            if4.mask = ~m;
          end else if (k == 3) begin
            if4.start = 1'b0;
          end
        end
        default: ;
      endcase
      ch = en[k / D4];
      sel = {if4.s1, if4.s0};
      n_cmp++;
      if (sel !== 2'(ch) || if4.busy !== 1'b1 || if4.done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s step %0d: sel=%0d busy=%b done=%b, required sel=%0d busy=1 done=0",
                 name, k, sel, if4.busy, if4.done, ch);
      end
      n_cmp++;
      if (if4.sample !== last_sample4) begin
        n_fail++;
        $display("FAIL %s hold step %0d: sample=%b required %b", name, k, if4.sample, last_sample4);
      end
      if (k % D4 == D4 - 1) exp[ch] = i4[ch];
      step();
    end
    sel = {if4.s1, if4.s0};
    n_cmp++;
    if (if4.done !== 1'b1 || if4.busy !== 1'b0 || sel !== 2'd0 || if4.sample !== exp) begin
      n_fail++;
      $display("FAIL %s complete: done=%b busy=%b sel=%0d sample=%b, required done=1 busy=0 sel=0 sample=%b",
               name, if4.done, if4.busy, sel, if4.sample, exp);
    end
    last_sample4 = exp;
    if4.mask = m;
    step();
    n_cmp++;
    if (if4.done !== 1'b0 || if4.busy !== 1'b0 || if4.sample !== exp) begin
      n_fail++;
      $display("FAIL %s after: done=%b busy=%b sample=%b, required done=0 busy=0 sample=%b",
               name, if4.done, if4.busy, if4.sample, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if4.start = 1'b0; if4.mask = 4'b0000;
    if1.start = 1'b0; if1.mask = 4'b0000;
    i4 = 4'b0000; i1 = 4'b0000;
    last_sample4 = 4'b0000;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({if4.s1, if4.s0, if4.busy, if4.done, if4.sample} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset4: s1s0=%b%b busy=%b done=%b sample=%b, required all 0",
               if4.s1, if4.s0, if4.busy, if4.done, if4.sample);
    end
    n_cmp++;
    if ({if1.s1, if1.s0, if1.busy, if1.done, if1.sample} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset1: s1s0=%b%b busy=%b done=%b sample=%b, required all 0",
               if1.s1, if1.s0, if1.busy, if1.done, if1.sample);
    end
  endtask

  task automatic test_full_scan();
    i4 = 4'b1101;
    run_scan(4'b1111, 0, "full_scan");
  endtask

  task automatic test_sparse();
    i4 = 4'b1111;
    run_scan(4'b1010, 0, "sparse");
    i4 = 4'b0101;
    run_scan(4'b0101, 0, "sparse_b");
  endtask

  task automatic test_mid_dwell();
    i4 = 4'($urandom);
    run_scan(4'b0001, 2, "mid_dwell");
    run_scan(4'b0001, 2, "mid_dwell_b");
  endtask

  task automatic test_random();
    logic [3:0] m;
    for (int r = 0; r < 8; r++) begin
      m = 4'($urandom_range(1, 15));
      run_scan(m, 1, "random");
    end
  endtask

  task automatic test_ignored();
    logic [1:0] sel;
    if4.mask = 4'b0000;
    if4.start = 1'b1;
    step();
    if4.start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      sel = {if4.s1, if4.s0};
      n_cmp++;
      if (if4.busy !== 1'b0 || if4.done !== 1'b0 || sel !== 2'd0 || if4.sample !== last_sample4) begin
        n_fail++;
        $display("FAIL zero_mask cyc %0d: busy=%b done=%b sel=%0d sample=%b, required 0/0/0/%b",
                 k, if4.busy, if4.done, sel, if4.sample, last_sample4);
      end
      step();
    end
    i4 = 4'($urandom);
    run_scan(4'b1111, 3, "midscan_inputs");
    i4 = 4'($urandom);
    run_scan(4'b0110, 3, "midscan_inputs_b");
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (if4.done !== 1'b0 || if4.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL single_done cyc %0d: done=%b busy=%b, required 0/0", k, if4.done, if4.busy);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [1:0] sel;
    i4 = 4'b1111;
    run_scan(4'b1111, 0, "pre_reset");
    if4.mask = 4'b1111;
    if4.start = 1'b1;
    step();
    if4.start = 1'b0;
    repeat (6) step();
    #2;
    rst_n = 1'b0;
    #1;
    sel = {if4.s1, if4.s0};
    n_cmp++;
    if (sel !== 2'd0 || if4.busy !== 1'b0 || if4.done !== 1'b0 || if4.sample !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset: sel=%0d busy=%b done=%b sample=%b, required 0/0/0/0000",
               sel, if4.busy, if4.done, if4.sample);
    end
    repeat (2) step();
    rst_n = 1'b1;
    last_sample4 = 4'b0000;
    for (int k = 0; k < 20; k++) begin
      n_cmp++;
      if (if4.done !== 1'b0 || if4.busy !== 1'b0 || if4.sample !== 4'b0000) begin
        n_fail++;
        $display("FAIL post_reset cyc %0d: done=%b busy=%b sample=%b, required 0/0/0000",
                 k, if4.done, if4.busy, if4.sample);
      end
      step();
    end
    i4 = 4'($urandom);
    run_scan(4'b1011, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    logic [1:0] sel;
    i1 = 4'($urandom);
    if1.mask = 4'b1111;
    if1.start = 1'b1;
    step();
    for (int s = 0; s < 5; s++) begin
      for (int p = 0; p < 4; p++) begin
        sel = {if1.s1, if1.s0};
        n_cmp++;
        if (sel !== 2'(p) || if1.busy !== 1'b1 || if1.done !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b scan %0d cyc %0d: sel=%0d busy=%b done=%b, required sel=%0d busy=1 done=0",
                   s, p, sel, if1.busy, if1.done, p);
        end
        step();
      end
      exp = i1;
      sel = {if1.s1, if1.s0};
      n_cmp++;
      if (if1.done !== 1'b1 || if1.busy !== 1'b0 || sel !== 2'd0 || if1.sample !== exp) begin
        n_fail++;
        $display("FAIL b2b scan %0d done: done=%b busy=%b sel=%0d sample=%b, required 1/0/0/%b",
                 s, if1.done, if1.busy, sel, if1.sample, exp);
      end
      i1 = 4'($urandom);
      if (s == 4) if1.start = 1'b0;
      step();
    end
    n_cmp++;
    if (if1.busy !== 1'b0 || if1.done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b stop: busy=%b done=%b, required 0/0", if1.busy, if1.done);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_full_scan();
    test_sparse();
    test_mid_dwell();
    test_random();
    test_ignored();
    test_reset_mid_scan();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
